// File: rtl/risc_v_cpu_pkg.sv
// Shared constants and ALU helper for the single-cycle RV32I core.
// The R-type OP group is built only when RV_RTYPE_EN is defined.
package risc_v_cpu_pkg;

  localparam int ROM_DEPTH = 4096;
  localparam int ROM_AW    = 12;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // alt selects SUB for ADD and arithmetic for right shift
  function automatic logic [31:0] alu(
    input logic [2:0]  f3,
    input logic        alt,
    input logic [31:0] a,
    input logic [31:0] b
  );
    case (f3)
      F3_ADD:  alu = alt ? a - b : a + b;
      F3_SLL:  alu = a << b[4:0];
      F3_SLT:  alu = {31'b0, $signed(a) < $signed(b)};
      F3_SLTU: alu = {31'b0, a < b};
      F3_XOR:  alu = a ^ b;
      F3_SR:   alu = alt ? 32'($signed(a) >>> b[4:0])
                         : a >> b[4:0];
      F3_OR:   alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

endpackage

// File: rtl/regs.sv
// 32x32 register file, two async read ports, one write port.
// x0 is never written and always reads zero.
module regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [0:31];

  // async clear, writes to x0 dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/risc_v_top.sv
// Single-cycle RV32I core: decode, ALU, next-PC, writeback.
// RV_RTYPE_EN enables the OP group; otherwise it retires as a NOP.
module risc_v_top
  import risc_v_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  output logic [ROM_AW-1:0] imem_addr
);

  logic [31:0] pc, pc_plus4, pc_next;
  logic [31:0] rs1_val, rs2_val, wb_val;
  logic [31:0] imm_i, imm_b, imm_j, imm_u;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        is_lui, is_auipc, is_jal, is_jalr;
  logic        is_br, is_opimm, is_op;
  logic        br_taken, we;

  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  assign is_lui   = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_jal   = opc == OPC_JAL;
  assign is_jalr  = opc == OPC_JALR;
  assign is_br    = opc == OPC_BRANCH;
  assign is_opimm = opc == OPC_OPIMM;
`ifdef RV_RTYPE_EN
  assign is_op    = opc == OPC_OP;
`else
  assign is_op    = 1'b0;
`endif

  assign we = is_lui | is_auipc | is_jal | is_jalr
            | is_opimm | is_op;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc[ROM_AW+1:2];

  // branch condition; undefined funct3 falls through
  always_comb begin
    br_taken = 1'b0;
    if (is_br) begin
      case (f3)
        F3_BEQ:  br_taken = rs1_val == rs2_val;
        F3_BNE:  br_taken = rs1_val != rs2_val;
        F3_BLT:  br_taken = $signed(rs1_val) < $signed(rs2_val);
        F3_BGE:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
        F3_BLTU: br_taken = rs1_val < rs2_val;
        F3_BGEU: br_taken = rs1_val >= rs2_val;
        default: br_taken = 1'b0;
      endcase
    end
  end

  // writeback value select
  always_comb begin
    wb_val = '0;
    unique case (1'b1)
      is_lui:   wb_val = imm_u;
      is_auipc: wb_val = pc + imm_u;
      is_jal,
      is_jalr:  wb_val = pc_plus4;
      is_opimm: wb_val = alu(f3, (f3 == F3_SR) & instr[30],
                             rs1_val, imm_i);
      is_op:    wb_val = alu(f3, instr[30], rs1_val, rs2_val);
      default:  wb_val = '0;
    endcase
  end

  // next pc select
  always_comb begin
    pc_next = pc_plus4;
    unique case (1'b1)
      is_jal:   pc_next = pc + imm_j;
      is_jalr:  pc_next = (rs1_val + imm_i) & ~32'd1;
      br_taken: pc_next = pc + imm_b;
      default:  pc_next = pc_plus4;
    endcase
  end

  // program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

  regs regs1 (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .ra2   (rs2),
    .rd1   (rs1_val),
    .rd2   (rs2_val),
    .we    (we),
    .wa    (rd),
    .wd    (wb_val)
  );

endmodule

// File: rtl/rom.sv
// Asynchronous-read instruction ROM, contents loaded externally.
// Word-indexed; the caller supplies pc[13:2].
module rom
  import risc_v_cpu_pkg::*;
(
  input  logic [ROM_AW-1:0] addr,
  output logic [31:0]       data
);

  logic [31:0] rom_mem [0:ROM_DEPTH-1];

  // combinational fetch
  assign data = rom_mem[addr];

endmodule

// File: rtl/risc_v_cpu.sv
// RV32I CPU top: internal ROM plus single-cycle core.
// Build option RV_RTYPE_EN adds the R-type OP group.
module risc_v_cpu
  import risc_v_cpu_pkg::*;
(
  input logic clk,
  input logic rst_n
);

  logic [ROM_AW-1:0] imem_addr;
  logic [31:0]       instr;

  rom rom1 (
    .addr (imem_addr),
    .data (instr)
  );

  risc_v_top risc_v_top1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .imem_addr (imem_addr)
  );

endmodule

// File: tb/tb_risc_v_cpu.sv
// Self-checking bench for risc_v_cpu: vector table,
// corner sequences and random programs against an ISA model.
module tb_risc_v_cpu;

  logic clk = 1'b1;
  logic rst_n;
  always #10 clk = ~clk;

  risc_v_cpu dut (
    .clk   (clk),
    .rst_n (rst_n)
  );

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [6:0] OI = 7'h13;
  localparam logic [6:0] OJR = 7'h67;
  localparam int NR = 40;

  typedef struct {
    int          pid;
    int          steps;
    int          ridx;
    logic [31:0] rval;
    logic [31:0] pcv;
  } vec_t;

  vec_t        vt [$];
  logic [31:0] progs [8][8];
  logic [31:0] img [64];
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  logic [2:0]  bfs [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  function automatic logic [31:0] e_i(logic [6:0] op,
    logic [4:0] rd, logic [2:0] f3, logic [4:0] rs1, int imm);
    logic [31:0] v = imm;
    return {v[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] e_r(logic [6:0] f7,
    logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3,
    logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] e_b(logic [2:0] f3,
    logic [4:0] rs1, logic [4:0] rs2, int off);
    logic [31:0] v = off;
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] e_j(logic [4:0] rd, int off);
    logic [31:0] v = off;
    return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] e_u(logic [6:0] op,
    logic [4:0] rd, logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rf_zero(input string nm);
    logic [31:0] a = '0;
    for (int r = 0; r < 32; r++)
      if (a === '0) a = dut.risc_v_top1.regs1.regs[r];
    chk(nm, a, 32'h0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #5;
    end
  endtask

  task automatic load_img();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4096; i++) dut.rom1.rom_mem[i] = '0;
    for (int i = 0; i < 64; i++) dut.rom1.rom_mem[i] = img[i];
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_img(input int pid);
    for (int i = 0; i < 64; i++) img[i] = '0;
    for (int i = 0; i < 8; i++) img[i] = progs[pid][i];
  endtask

  // ISA-level reference: one retired instruction per call
  task automatic m_step();
    logic [31:0] w, a, b, ii, ib, ij, val, npc;
    logic [4:0]  rd, sh;
    logic [2:0]  f3;
    logic        wr;
    int          idx;
    idx = int'(m_pc[13:2]);
    w = (idx < 64) ? img[idx] : 32'h0;
    rd = w[11:7];
    f3 = w[14:12];
    a = m_rf[w[19:15]];
    b = m_rf[w[24:20]];
    ii = 32'(int'($signed(w[31:20])));
    ib = 32'(int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})));
    ij = 32'(int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})));
    npc = m_pc + 4;
    wr = 1'b0;
    val = '0;
    if (w[6:0] == 7'h13 || w[6:0] == 7'h33) begin
      logic [31:0] y;
      y = (w[6:0] == 7'h13) ? ii : b;
      sh = y[4:0];
      wr = 1'b1;
      case (f3)
        0: val = (w[6:0] == 7'h33 && w[30]) ? a - y : a + y;
        1: val = a << sh;
        2: val = (int'(a) < int'(y)) ? 1 : 0;
        3: val = (a < y) ? 1 : 0;
        4: val = a ^ y;
        5: begin
          val = a >> sh;
          if (w[30] && a[31]) val = val | ~(32'hffff_ffff >> sh);
        end
        6: val = a | y;
        default: val = a & y;
      endcase
`ifndef RV_RTYPE_EN
      if (w[6:0] == 7'h33) wr = 1'b0;
`endif
    end else begin
      case (w[6:0])
        7'h37: begin wr = 1'b1; val = {w[31:12], 12'h0}; end
        7'h17: begin wr = 1'b1; val = m_pc + {w[31:12], 12'h0}; end
        7'h6f: begin wr = 1'b1; val = m_pc + 4; npc = m_pc + ij; end
        7'h67: begin
          wr = 1'b1; val = m_pc + 4; npc = (a + ii) & 32'hffff_fffe;
        end
        7'h63: begin
          logic t;
          case (f3)
            0: t = a == b;
            1: t = a != b;
            4: t = int'(a) < int'(b);
            5: t = int'(a) >= int'(b);
            6: t = a < b;
            7: t = a >= b;
            default: t = 1'b0;
          endcase
          if (t) npc = m_pc + ib;
        end
        default: wr = 1'b0;
      endcase
    end
    if (wr && rd != 0) m_rf[rd] = val;
    m_pc = npc;
  endtask

  task automatic chk_model(input string nm);
    logic [31:0] a = '0, e = '0;
    for (int r = 0; r < 32; r++)
      if (a === e && dut.risc_v_top1.regs1.regs[r] !== m_rf[r]) begin
        a = dut.risc_v_top1.regs1.regs[r];
        e = m_rf[r];
      end
    chk({nm, "_rf"}, a, e);
    chk({nm, "_pc"}, dut.risc_v_top1.pc, m_pc);
  endtask

  task automatic gen_rand();
    int k;
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    for (int i = 0; i < 64; i++) img[i] = '0;
    for (int i = 0; i < NR - 1; i++) begin
      k = $urandom_range(0, 5);
      rd = 5'($urandom_range(0, 15));
      r1 = 5'($urandom_range(0, 15));
      r2 = 5'($urandom_range(0, 15));
      f3 = 3'($urandom_range(0, 7));
      if (k >= 4 && i > NR - 6) k = 0;
      case (k)
        0, 1: begin
          int imm = $urandom_range(0, 4095);
          if (f3 == 1) imm = imm & 31;
          if (f3 == 5) imm = (imm & 31) | ($urandom_range(0, 1) << 10);
          img[i] = e_i(OI, rd, f3, r1, imm);
        end
        2: img[i] = e_u($urandom_range(0, 1) ? 7'h37 : 7'h17,
                        rd, 20'($urandom));
        3: img[i] = e_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1))
                        ? 7'h20 : 7'h00, r2, r1, f3, rd);
        4: img[i] = e_b(bfs[$urandom_range(0, 5)], r1, r2,
                        $urandom_range(0, 1) ? 8 : 12);
        default: img[i] = e_j(rd, 8);
      endcase
    end
    img[NR-1] = e_j(5'd0, 0);
  endtask

  initial begin
    logic [31:0] exp7;
    int t;
    for (int p = 0; p < 8; p++)
      for (int i = 0; i < 8; i++) progs[p][i] = '0;
    progs[0][0] = e_i(OI, 1, 0, 0, 5);
    progs[0][1] = e_i(OI, 0, 0, 0, 7);
    progs[1][0] = e_u(7'h37, 2, 20'h80000);
    progs[1][1] = e_i(OI, 3, 5, 2, 'h404);
    progs[1][2] = e_i(OI, 4, 3, 0, 1);
    progs[2][0] = e_i(OI, 5, 0, 0, -1);
    progs[2][1] = e_i(OI, 6, 0, 0, 1);
    progs[2][2] = e_b(3'd6, 5, 6, 8);
    progs[2][3] = e_i(OI, 8, 0, 0, 1);
    progs[2][4] = e_b(3'd4, 5, 6, 8);
    progs[2][5] = e_i(OI, 9, 0, 0, 1);
    progs[2][6] = e_i(OI, 10, 0, 0, 2);
    progs[3][0] = e_j(1, 8);
    progs[3][1] = e_i(OI, 11, 0, 0, 3);
    progs[3][2] = e_i(OJR, 0, 0, 1, 0);
    progs[4][0] = e_i(OI, 5, 0, 0, 3);
    progs[4][1] = e_i(OI, 6, 0, 0, 5);
    progs[4][2] = e_r(7'h20, 6, 5, 0, 7);
    progs[5][0] = e_i(OI, 1, 0, 0, 17);
    progs[5][1] = e_i(OJR, 2, 0, 1, 0);
    progs[6][0] = e_j(0, 'h4000);
    progs[7][0] = 32'h0010_2023;
    progs[7][1] = 32'h0000_000f;
    progs[7][2] = 32'h0000_0073;
    progs[7][3] = e_i(OI, 12, 0, 0, 9);
`ifdef RV_RTYPE_EN
    exp7 = 32'hffff_fffe;
`else
    exp7 = 32'h0;
`endif
    vt = '{
      '{0, 1, 1, 32'h5, 32'h4},
      '{0, 2, 0, 32'h0, 32'h8},
      '{0, 2, 1, 32'h5, 32'h8},
      '{1, 3, 2, 32'h8000_0000, 32'hc},
      '{1, 3, 3, 32'hf800_0000, 32'hc},
      '{1, 3, 4, 32'h1, 32'hc},
      '{2, 3, 5, 32'hffff_ffff, 32'hc},
      '{2, 5, 8, 32'h1, 32'h18},
      '{2, 6, 9, 32'h0, 32'h1c},
      '{2, 6, 10, 32'h2, 32'h1c},
      '{3, 1, 1, 32'h4, 32'h8},
      '{3, 2, 1, 32'h4, 32'h4},
      '{3, 3, 11, 32'h3, 32'h8},
      '{4, 3, 7, exp7, 32'hc},
      '{5, 2, 2, 32'h8, 32'h10},
      '{6, 1, 0, 32'h0, 32'h4000},
      '{6, 2, 0, 32'h0, 32'h8000},
      '{7, 4, 12, 32'h9, 32'h10},
      '{7, 3, 1, 32'h0, 32'hc}
    };

    rst_n = 1'b0;
    set_img(0);
    for (int i = 0; i < 4096; i++) dut.rom1.rom_mem[i] = '0;
    for (int i = 0; i < 64; i++) dut.rom1.rom_mem[i] = img[i];
    #25;
    chk("reset_pc", dut.risc_v_top1.pc, 32'h0);
    chk_rf_zero("reset_rf");
    #5 rst_n = 1'b1;
    step(1);
    chk("first_x1", dut.risc_v_top1.regs1.regs[1], 32'h5);
    chk("first_pc", dut.risc_v_top1.pc, 32'h4);

    foreach (vt[i]) begin
      set_img(vt[i].pid);
      load_img();
      step(vt[i].steps);
      chk($sformatf("vec%0d_x%0d", i, vt[i].ridx),
          dut.risc_v_top1.regs1.regs[vt[i].ridx], vt[i].rval);
      chk($sformatf("vec%0d_pc", i), dut.risc_v_top1.pc, vt[i].pcv);
    end

    set_img(2);
    load_img();
    step(3);
    chk("mid_x5", dut.risc_v_top1.regs1.regs[5], 32'hffff_ffff);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", dut.risc_v_top1.pc, 32'h0);
    chk_rf_zero("mid_rst_rf");
    @(posedge clk);
    #5;
    chk("hold_rst_pc", dut.risc_v_top1.pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(6);
    chk("rerun_x8", dut.risc_v_top1.regs1.regs[8], 32'h1);
    chk("rerun_x10", dut.risc_v_top1.regs1.regs[10], 32'h2);
    chk("rerun_pc", dut.risc_v_top1.pc, 32'h1c);

    for (int r = 0; r < 3; r++) begin
      gen_rand();
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_pc = '0;
      load_img();
      for (int s = 0; s < 50; s++) begin
        step(1);
        m_step();
        chk_model($sformatf("rand%0d_s%0d", r, s));
      end
    end

    for (int i = 0; i < 64; i++) img[i] = '0;
    img[0] = e_i(OI, 26, 0, 0, 1);
    img[1] = e_i(OI, 27, 0, 0, 1);
    img[2] = e_j(0, 0);
    load_img();
    t = 0;
    while (t < 50 && dut.risc_v_top1.regs1.regs[26] != 1 &&
           dut.risc_v_top1.regs1.regs[27] != 1) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL pass_wait: x26/x27 never set within 50 cycles");
    end else begin
      #200;
      chk("pass_x26", dut.risc_v_top1.regs1.regs[26], 32'h1);
      chk("pass_x27", dut.risc_v_top1.regs1.regs[27], 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
